ram_loader: RTL and testbench
=============================

RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter CLK_HZ, default 27000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate; DIV = CLK_HZ/BAUD (integer division), DIV >= 4.
REQ-003 Parameter STROBE_CYCLES, default 4, number of clk cycles load_we is held high per RAM write.
REQ-004 clk  input  1  system clock; the block has one clock and all logic is on it.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 rx  input  1  UART receive line: idle high, 8N1, LSB first, asynchronous to clk.
REQ-007 cpu_hold  output  1  holds the CPU in reset from frame header until write-back ends.
REQ-008 load_active  output  1  RAM manual-programming mode select, high during write-back only.
REQ-009 load_addr  output  4  RAM address for the current write.
REQ-010 load_data  output  8  RAM data for the current write.
REQ-011 load_we  output  1  manual write strobe.
REQ-012 done  output  1  high after a complete successful load; cleared by the next header.
REQ-013 error  output  1  sticky failure flag (framing or checksum); cleared by the next header.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-015 Receiver: a falling edge in idle starts a bit counter; start bit is sampled at DIV/2; if it reads high, reception is aborted silently.
REQ-016 Data bits SHALL be sampled every DIV cycles after the start-bit sample, LSB first; the stop bit is sampled one DIV later.
REQ-017 Stop bit low = framing error: byte discarded, error=1, loader FSM to IDLE; receiver resumes hunting after rx returns high.
REQ-018 A valid byte produces a one-cycle internal rx_valid on the stop-bit sample cycle.
REQ-019 Loader FSM states: IDLE, RECV, CHECK, WRITE, DONE.
REQ-020 IDLE: byte 0xA5 -> RECV with index 0, cpu_hold=1, done=0, error=0; any other byte is ignored.
REQ-021 RECV: each byte is stored in a 16x8 buffer at the current index; after index 15 -> CHECK (or WRITE, see REQ-030).
REQ-022 CHECK: next byte compared with the 8-bit sum mod 256 of the 16 buffered bytes; match -> WRITE; mismatch -> IDLE, error=1, cpu_hold=0, RAM untouched.
REQ-023 WRITE: for addresses 0..15 ascending, each entry takes SETUP (1 cycle, addr/data valid, we=0), STROBE (STROBE_CYCLES cycles, we=1), HOLD (1 cycle, we=0); load_addr/load_data stay stable across all three.
REQ-024 load_active SHALL be 1 for the whole of WRITE, from the first SETUP through the last HOLD inclusive, and 0 otherwise.
REQ-025 After address 15 HOLD -> DONE: done=1, cpu_hold=0, load_active=0; DONE behaves as IDLE (0xA5 starts a new frame).
REQ-026 Bytes arriving during WRITE SHALL be discarded; the receiver keeps running.
REQ-027 A framing error in RECV or CHECK aborts the frame per REQ-017 and deasserts cpu_hold.

Reset
REQ-028 On rst_n low, at any point including mid-byte or mid-WRITE, all outputs SHALL go to 0 immediately, the FSM to IDLE, the receiver to idle, and the buffer index to 0; buffer contents are don't-care.

Configuration
REQ-029 Macro LOADER_CHECKSUM_EN defined: frame = 0xA5 + 16 data + checksum, and CHECK is implemented.
REQ-030 Macro not defined: frame = 0xA5 + 16 data, RECV goes directly to WRITE, CHECK does not exist, and error is raised only by framing errors.

Verification (CLK_HZ=1000000, BAUD=100000, DIV=10, STROBE_CYCLES=4)
REQ-031 Send A5, 00..0F, 78 -> 16 strobes, addr n carries data n, each strobe is 4 cycles high, then done=1, error=0, cpu_hold=0.
REQ-032 Send A5, 00..0F, 77 -> no load_we pulses, error=1, done=0, cpu_hold falls after the checksum byte.
REQ-033 Send 3C then A5, 16x FF, F0 -> 3C ignored, all addresses written FF, done=1.
REQ-034 Send A5, then a byte with stop bit forced low -> error=1, FSM in IDLE, cpu_hold=0; a following valid frame succeeds and clears error.
REQ-035 Pulse rst_n low during the 8th strobe of a valid frame -> all outputs 0 within the reset, no further strobes; a new frame then loads correctly.
REQ-036 With LOADER_CHECKSUM_EN undefined: send A5, 00..0F -> 16 writes start without waiting for a checksum byte, done=1.

Source files
------------

// File: rtl/ram_loader.sv
// UART-driven loader: receives a 0xA5-headed frame of 16 bytes and writes them into a 16x8 RAM.
// Define LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte before the write-back.
module ram_loader #(
    parameter int CLK_HZ        = 27000000,
    parameter int BAUD          = 115200,
    parameter int STROBE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       cpu_hold,
    output logic       load_active,
    output logic [3:0] load_addr,
    output logic [7:0] load_data,
    output logic       load_we,
    output logic       done,
    output logic       error
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(DIV + 1);
    localparam int SW  = $clog2(STROBE_CYCLES + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);
    localparam logic [SW-1:0] STB_M1  = SW'(STROBE_CYCLES - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
    typedef enum logic [2:0] {L_IDLE, L_RECV, L_CHECK, L_WRITE, L_DONE} l_state_t;
    typedef enum logic [1:0] {W_SETUP, W_STROBE, W_HOLD} w_phase_t;

    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   baud_cnt_q, baud_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            baud_tick, rx_valid, rx_ferr;

    l_state_t        state_q, state_d;
    w_phase_t        phase_q, phase_d;
    logic [3:0]      idx_q, idx_d;
    logic [SW-1:0]   stb_cnt_q, stb_cnt_d;
    logic            done_q, done_d, error_q, error_d;
    logic            mem_we;
    logic [7:0]      mem_q [16];
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]      sum_q, sum_d;
`endif

    // ---------------- receiver ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
        end
    end

    // The start bit is sampled half a bit in; every later sample is a full bit apart.
    assign baud_tick = (baud_cnt_q == ((rx_state_q == RX_START) ? HALF_M1 : FULL_M1));

    always_comb begin
        rx_state_d = rx_state_q;
        baud_cnt_d = baud_cnt_q + 1'b1;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        case (rx_state_q)
            RX_IDLE: begin
                baud_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: if (baud_tick) begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (baud_tick) begin
                baud_cnt_d = '0;
                shift_d    = {rx_sync_q, shift_q[7:1]};
                bit_cnt_d  = bit_cnt_q + 1'b1;
                if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: if (baud_tick) begin
                baud_cnt_d = '0;
                rx_state_d = rx_sync_q ? RX_IDLE : RX_WAIT;
            end
            RX_WAIT: begin
                baud_cnt_d = '0;
                if (rx_sync_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_valid = (rx_state_q == RX_STOP) && baud_tick && rx_sync_q;
        rx_ferr  = (rx_state_q == RX_STOP) && baud_tick && !rx_sync_q;
    end

    // ---------------- loader ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= L_IDLE;
            phase_q   <= W_SETUP;
            idx_q     <= '0;
            stb_cnt_q <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            idx_q     <= idx_d;
            stb_cnt_q <= stb_cnt_d;
            done_q    <= done_d;
            error_q   <= error_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

    // Buffer contents are never reset; only the index matters after reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[idx_q] <= shift_q;
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        idx_d     = idx_q;
        stb_cnt_d = stb_cnt_q;
        done_d    = done_q;
        error_d   = error_q;
        mem_we    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        case (state_q)
            L_IDLE, L_DONE: begin
                if (rx_valid && shift_q == 8'hA5) begin
                    state_d = L_RECV;
                    idx_d   = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end else if (rx_ferr) begin
                    state_d = L_IDLE;
                    error_d = 1'b1;
                end
            end
            L_RECV: begin
                if (rx_ferr) begin
                    state_d = L_IDLE;
                    error_d = 1'b1;
                end else if (rx_valid) begin
                    mem_we = 1'b1;
                    idx_d  = idx_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d  = sum_q + shift_q;
                    if (idx_q == 4'd15) state_d = L_CHECK;
`else
                    if (idx_q == 4'd15) begin
                        state_d = L_WRITE;
                        phase_d = W_SETUP;
                    end
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            L_CHECK: begin
                if (rx_ferr) begin
                    state_d = L_IDLE;
                    error_d = 1'b1;
                end else if (rx_valid) begin
                    if (shift_q == sum_q) begin
                        state_d = L_WRITE;
                        phase_d = W_SETUP;
                    end else begin
                        state_d = L_IDLE;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            // Incoming bytes and line errors are ignored while writing back.
            L_WRITE: begin
                case (phase_q)
                    W_SETUP: begin
                        phase_d   = W_STROBE;
                        stb_cnt_d = '0;
                    end
                    W_STROBE: begin
                        stb_cnt_d = stb_cnt_q + 1'b1;
                        if (stb_cnt_q == STB_M1) phase_d = W_HOLD;
                    end
                    default: begin
                        phase_d = W_SETUP;
                        idx_d   = idx_q + 1'b1;
                        if (idx_q == 4'd15) begin
                            state_d = L_DONE;
                            done_d  = 1'b1;
                        end
                    end
                endcase
            end
            default: state_d = L_IDLE;
        endcase
    end

    always_comb begin
        cpu_hold    = (state_q == L_RECV) || (state_q == L_CHECK) || (state_q == L_WRITE);
        load_active = (state_q == L_WRITE);
        load_we     = load_active && (phase_q == W_STROBE);
        load_addr   = load_active ? idx_q : 4'd0;
        load_data   = load_active ? mem_q[idx_q] : 8'd0;
        done        = done_q;
        error       = error_q;
    end
endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: frame table plus framing-error and mid-write reset sequences.
module tb_ram_loader;
    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 100000;
    localparam int DIV    = 10;
    localparam int SC     = 4;
    localparam int ACTIVE_CYCLES = 16 * (SC + 2);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       cpu_hold, load_active, load_we, done, error;
    logic [3:0] load_addr;
    logic [7:0] load_data;

    always #5 clk = ~clk;

    ram_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .STROBE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .cpu_hold(cpu_hold), .load_active(load_active),
        .load_addr(load_addr), .load_data(load_data), .load_we(load_we), .done(done), .error(error)
    );

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];
    int strobes = 0;
    logic full_run = 1'b1;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every completed strobe is matched against exp_q.
    logic       prev_we = 1'b0, prev_act = 1'b0;
    int         we_len = 0, act_len = 0;
    logic [3:0] cur_addr = '0;
    logic [7:0] cur_data = '0;
    logic [11:0] exp_w;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_we = 1'b0; prev_act = 1'b0; we_len = 0; act_len = 0;
        end else begin
            if (load_we && !prev_we) begin
                cur_addr = load_addr; cur_data = load_data; we_len = 0;
            end
            if (load_we) begin
                we_len++;
                check("strobe_stable", {load_addr, load_data}, {cur_addr, cur_data});
                check("we_inside_active", load_active, 1);
            end
            if (!load_we && prev_we) begin
                strobes++;
                check("strobe_len", we_len, SC);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_strobe: addr %0d data 0x%0h, none expected", cur_addr, cur_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("strobe_addr_data", {cur_addr, cur_data}, exp_w);
                end
            end
            if (load_active) act_len++;
            if (!load_active && prev_act && full_run) check("active_len", act_len, ACTIVE_CYCLES);
            if (!load_active) act_len = 0;
            prev_we = load_we; prev_act = load_active;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk); rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop_bit;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [7:0] dbyte(input logic [7:0] base, input logic [7:0] step, input int i);
        logic [7:0] k;
        k = 8'(i);
        return base + step * k;
    endfunction

    task automatic push_frame(input logic [7:0] base, input logic [7:0] step, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({4'(i), dbyte(base, step, i)});
    endtask

    // Sends header, 16 data bytes and, when checksums are built in, sum + adj.
    task automatic send_frame(input logic [7:0] base, input logic [7:0] step, input logic [7:0] adj);
        logic [7:0] sum;
        sum = 8'h00;
        send_byte(8'hA5, 1'b1);
        check("hold_after_header", cpu_hold, 1);
        check("flags_cleared_by_header", {done, error}, 0);
        for (int i = 0; i < 16; i++) begin
            send_byte(dbyte(base, step, i), 1'b1);
            sum = sum + dbyte(base, step, i);
        end
`ifdef LOADER_CHECKSUM_EN
        check("hold_before_checksum", cpu_hold, 1);
        send_byte(sum + adj, 1'b1);
`else
        if (adj != 8'h00) $display("note: checksum adjust ignored in this build");
`endif
    endtask

    task automatic wait_end(input int budget);
        int n;
        n = 0;
        while (!(done || error) && n < budget) begin
            @(negedge clk); n++;
        end
        if (!(done || error)) begin
            checks++; errors++;
            $display("FAIL frame_end_timeout: no done/error within %0d cycles", budget);
        end
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic       send_lead;
        logic [7:0] lead;
        logic [7:0] base;
        logic [7:0] step;
        logic [7:0] chk_adj;
        logic       exp_done;
        logic       exp_error;
        int         exp_writes;
    } vec_t;
    vec_t vecs[4];

    initial begin : watchdog
        #700000;
        errors++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : main
        int s0, n;
        vecs[0] = '{1'b0, 8'h00, 8'h00, 8'h01, 8'h00, 1'b1, 1'b0, 16};
        vecs[1] = '{1'b0, 8'h00, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1, 0};
        vecs[2] = '{1'b1, 8'h3C, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 16};
        vecs[3] = '{1'b0, 8'h00, 8'h11, 8'h23, 8'h00, 1'b1, 1'b0, 16};

        repeat (4) @(negedge clk);
        check("reset_outputs", {cpu_hold, load_active, load_addr, load_data, load_we, done, error}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_outputs", {cpu_hold, load_active, load_we, done, error}, 0);

        for (int v = 0; v < 4; v++) begin
`ifndef LOADER_CHECKSUM_EN
            if (vecs[v].chk_adj != 8'h00) continue;
`endif
            push_frame(vecs[v].base, vecs[v].step, vecs[v].exp_writes);
            s0 = strobes;
            if (vecs[v].send_lead) begin
                send_byte(vecs[v].lead, 1'b1);
                check("lead_byte_ignored", cpu_hold, 0);
            end
            send_frame(vecs[v].base, vecs[v].step, vecs[v].chk_adj);
            wait_end(400);
            check("vec_done", done, vecs[v].exp_done);
            check("vec_error", error, vecs[v].exp_error);
            check("vec_hold_released", {cpu_hold, load_active}, 0);
            check("vec_strobe_count", strobes - s0, vecs[v].exp_writes);
            check("vec_all_writes_seen", exp_q.size(), 0);
        end

        // Framing error right after the header aborts the frame.
        send_byte(8'hA5, 1'b1);
        check("ferr_hold_after_header", cpu_hold, 1);
        send_byte(8'h12, 1'b0);
        check("ferr_flags", {done, error}, 2'b01);
        check("ferr_hold_released", {cpu_hold, load_active}, 0);
        push_frame(8'h80, 8'h07, 16);
        send_frame(8'h80, 8'h07, 8'h00);
        wait_end(400);
        check("after_ferr_flags", {done, error}, 2'b10);
        check("after_ferr_writes_seen", exp_q.size(), 0);

        // Reset during the 8th strobe; only the first 7 writes may complete.
        full_run = 1'b0;
        push_frame(8'h20, 8'h03, 7);
        s0 = strobes;
        send_frame(8'h20, 8'h03, 8'h00);
        n = 0;
        while (!(strobes == s0 + 7 && load_we) && n < 400) begin
            @(negedge clk); n++;
        end
        check("reached_8th_strobe", {strobes - s0, 1'(load_we)}, {7, 1'b1});
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", {cpu_hold, load_active, load_addr, load_data, load_we, done, error}, 0);
        repeat (3) @(negedge clk);
        check("held_reset_outputs", {cpu_hold, load_active, load_addr, load_data, load_we, done, error}, 0);
        #2 rst_n = 1'b1;
        repeat (150) @(negedge clk);
        check("no_strobes_after_reset", strobes - s0, 7);
        check("idle_after_reset", {cpu_hold, load_active, done, error}, 0);
        check("partial_writes_seen", exp_q.size(), 0);
        full_run = 1'b1;

        push_frame(8'h40, 8'h05, 16);
        s0 = strobes;
        send_frame(8'h40, 8'h05, 8'h00);
        wait_end(400);
        check("post_reset_flags", {done, error, cpu_hold}, 3'b100);
        check("post_reset_strobes", strobes - s0, 16);
        check("post_reset_writes_seen", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
